// File: rtl/shift_pkg.sv
// Shared opcodes, default datapath width and shift-amount normalization for the
// shift/rotate execution unit.
package shift_pkg;

    localparam int DEFAULT_DATA_WIDTH = 20;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 3'd0,
        OP_ROR = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_SAR = 3'd4
    } op_e;

    // Amounts are carried at a fixed wide width so the helpers serve any
    // DATA_WIDTH up to AMT_W.
    localparam int AMT_W = 64;
    typedef logic [AMT_W-1:0] amt_t;

    function automatic logic is_rotate(input logic [OP_W-1:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    // Rotates wrap modulo the width; shifts saturate at the width.
    function automatic amt_t norm_amount(input amt_t amount, input logic [OP_W-1:0] op,
                                         input amt_t width);
        if (is_rotate(op)) begin
            return amount % width;
        end
        if (amount > width) begin
            return width;
        end
        return amount;
    endfunction

endpackage

// File: rtl/shift_exec_rotleft.sv
// Combinational rotate-left core shared by every shift/rotate flavour.
// shift_amount must be below DATA_WIDTH.
module rotleft #(
    parameter int DATA_WIDTH = 20,
    parameter int SHIFT_W    = 5
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [SHIFT_W-1:0]    shift_amount,
    output logic [DATA_WIDTH-1:0] data_out
);

    // A zero amount shifts the wrap-around term by the full width, which yields 0.
    assign data_out = (data_in << shift_amount) | (data_in >> (DATA_WIDTH - shift_amount));

endmodule

// File: rtl/shift_exec.sv
// Two-stage shift/rotate execution unit: stage 1 decodes and normalizes the amount,
// stage 2 runs rotleft, applies masks/sign fill and registers result plus flags.
module shift_exec
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_amount,
    input  logic [OP_W-1:0]       in_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_zero,
    output logic                  out_neg,
    output logic                  out_carry,
    output logic                  out_illegal
);

    localparam int                    SH_W = $clog2(DATA_WIDTH + 1);
    localparam logic [SH_W-1:0]       W_S  = SH_W'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONES = '1;
    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic [OP_W-1:0]       r_s1_op;
    logic [TAG_WIDTH-1:0]  r_s1_tag;
    logic [SH_W-1:0]       r_s1_amt;
    logic                  r_s1_over;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [TAG_WIDTH-1:0]  r_out_tag;
    logic                  r_out_zero;
    logic                  r_out_neg;
    logic                  r_out_carry;
    logic                  r_out_illegal;

    logic                  w_s2_adv;
    logic                  w_s1_load;
    logic                  w_accept;
    amt_t                  w_amt_ext;
    logic [SH_W-1:0]       w_rot_amt;
    logic [DATA_WIDTH-1:0] w_rot_out;
    logic [DATA_WIDTH-1:0] w_low_mask;
    logic [DATA_WIDTH-1:0] w_high_mask;
    logic [DATA_WIDTH-1:0] w_shl_sel;
    logic [DATA_WIDTH-1:0] w_shr_sel;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_carry;
    logic                  w_illegal;

    // Handshake: a transfer happens on a rising edge where valid && ready; ready
    // never looks at valid, and a stalled output holds every field stable.
    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_adv;
    assign in_ready  = !flush && w_s1_load;
    assign w_accept  = in_valid && in_ready;

    assign w_amt_ext = amt_t'(in_amount);

    always_comb begin
        w_rot_amt = '0;
        case (r_s1_op)
            OP_ROL:                 w_rot_amt = r_s1_amt;
            OP_SHL:                 w_rot_amt = (r_s1_amt == W_S) ? '0 : r_s1_amt;
            OP_ROR, OP_SHR, OP_SAR: w_rot_amt = (r_s1_amt == '0) ? '0 : W_S - r_s1_amt;
            default:                w_rot_amt = '0;
        endcase
    end

    rotleft #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_W    (SH_W)
    ) u_rotleft (
        .data_in      (r_s1_data),
        .shift_amount (w_rot_amt),
        .data_out     (w_rot_out)
    );

    // One-hot selects pick the last bit shifted out; a zero amount selects nothing.
    assign w_low_mask  = ONES >> (W_S - r_s1_amt);
    assign w_high_mask = ~(ONES >> r_s1_amt);
    assign w_shl_sel   = ONE << (W_S - r_s1_amt);
    assign w_shr_sel   = ONE << (r_s1_amt - SH_W'(1));
    assign w_sign      = r_s1_data[DATA_WIDTH-1];

    always_comb begin
        w_result  = r_s1_data;
        w_carry   = 1'b0;
        w_illegal = 1'b0;
        case (r_s1_op)
            OP_ROL: begin
                w_result = w_rot_out;
                w_carry  = (r_s1_amt != '0) && w_rot_out[0];
            end
            OP_ROR: begin
                w_result = w_rot_out;
                w_carry  = (r_s1_amt != '0) && w_rot_out[DATA_WIDTH-1];
            end
            OP_SHL: begin
                w_result = w_rot_out & ~w_low_mask;
                w_carry  = !r_s1_over && (|(r_s1_data & w_shl_sel));
            end
            OP_SHR: begin
                w_result = w_rot_out & ~w_high_mask;
                w_carry  = !r_s1_over && (|(r_s1_data & w_shr_sel));
            end
            OP_SAR: begin
                w_result = (w_rot_out & ~w_high_mask) | (w_sign ? w_high_mask : '0);
                w_carry  = r_s1_over ? w_sign : (|(r_s1_data & w_shr_sel));
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_op       <= '0;
            r_s1_tag      <= '0;
            r_s1_amt      <= '0;
            r_s1_over     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_tag     <= '0;
            r_out_zero    <= 1'b0;
            r_out_neg     <= 1'b0;
            r_out_carry   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_load) begin
                r_s1_valid <= w_accept;
            end

            if (w_accept) begin
                r_s1_data <= in_data;
                r_s1_op   <= in_op;
                r_s1_tag  <= in_tag;
                r_s1_amt  <= SH_W'(norm_amount(w_amt_ext, in_op, amt_t'(DATA_WIDTH)));
                r_s1_over <= w_amt_ext > amt_t'(DATA_WIDTH);
            end

            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
            end

            if (!flush && w_s2_adv && r_s1_valid) begin
                r_out_data    <= w_result;
                r_out_tag     <= r_s1_tag;
                r_out_zero    <= (w_result == '0);
                r_out_neg     <= w_result[DATA_WIDTH-1];
                r_out_carry   <= w_carry;
                r_out_illegal <= w_illegal;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_tag     = r_out_tag;
    assign out_zero    = r_out_zero;
    assign out_neg     = r_out_neg;
    assign out_carry   = r_out_carry;
    assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_shift_exec.sv
// Bench for shift_exec: directed vectors plus randomized traffic, checked every
// cycle against a bit-serial reference model and an in-order expected queue.
module tb_shift_exec;
    import shift_pkg::*;

    localparam int W  = 20;
    localparam int TW = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [W-1:0]  in_amount = '0;
    logic [2:0]    in_op     = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          out_zero;
    logic          out_neg;
    logic          out_carry;
    logic          out_illegal;

    shift_exec #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_amount   (in_amount),
        .in_op       (in_op),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_carry   (out_carry),
        .out_illegal (out_illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic          zero;
        logic          neg;
        logic          carry;
        logic          ill;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Bit-at-a-time semantics: carry is the last bit moved out of the word.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] amt,
                                   input logic [2:0] op, input logic [TW-1:0] tag);
        exp_t         e;
        logic [W-1:0] res;
        logic         c;
        int           k;
        res   = a;
        c     = 1'b0;
        e.ill = 1'b0;
        case (op)
            3'd0: begin
                k = int'(amt) % W;
                for (int i = 0; i < k; i++) res = {res[W-2:0], res[W-1]};
                c = (k != 0) ? res[0] : 1'b0;
            end
            3'd1: begin
                k = int'(amt) % W;
                for (int i = 0; i < k; i++) res = {res[0], res[W-1:1]};
                c = (k != 0) ? res[W-1] : 1'b0;
            end
            3'd2, 3'd3, 3'd4: begin
                k = (int'(amt) > W) ? W + 1 : int'(amt);
                for (int i = 0; i < k; i++) begin
                    if (op == 3'd2) begin
                        c   = res[W-1];
                        res = res << 1;
                    end else if (op == 3'd3) begin
                        c   = res[0];
                        res = res >> 1;
                    end else begin
                        c   = res[0];
                        res = {res[W-1], res[W-1:1]};
                    end
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.data  = res;
        e.tag   = tag;
        e.zero  = (res == '0);
        e.neg   = res[W-1];
        e.carry = c;
        e.acc   = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    exp_t mon_e;
    bit   mon_ov;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            mon_ov = 1'b0;
            if (exp_q.size() > 0) mon_ov = (cyc - exp_q[0].acc) >= 2;
            check("out_valid", 32'(out_valid), 32'(mon_ov));
            if (out_valid && exp_q.size() > 0) begin
                check("out_data",    32'(out_data),    32'(exp_q[0].data));
                check("out_tag",     32'(out_tag),     32'(exp_q[0].tag));
                check("out_zero",    32'(out_zero),    32'(exp_q[0].zero));
                check("out_neg",     32'(out_neg),     32'(exp_q[0].neg));
                check("out_carry",   32'(out_carry),   32'(exp_q[0].carry));
                check("out_illegal", 32'(out_illegal), 32'(exp_q[0].ill));
            end
            check("in_ready", 32'(in_ready), 32'(!flush && (exp_q.size() < 2 || out_ready)));
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            if (in_valid && in_ready) begin
                mon_e     = model(in_data, in_amount, in_op, in_tag);
                mon_e.acc = cyc;
                exp_q.push_back(mon_e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] amt,
                        input logic [2:0] op, input logic [TW-1:0] tag);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        in_amount = amt;
        in_op     = op;
        in_tag    = tag;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic try_once(input logic [W-1:0] a, input logic [W-1:0] amt,
                            input logic [2:0] op, input logic [TW-1:0] tag, output bit acc);
        in_valid  = 1'b1;
        in_data   = a;
        in_amount = amt;
        in_op     = op;
        in_tag    = tag;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_data"},  32'(out_data),  32'd0);
        check({name, "_tag"},   32'(out_tag),   32'd0);
        check({name, "_flags"}, 32'({out_zero, out_neg, out_carry, out_illegal}), 32'd0);
    endtask

    task automatic pin_model();
        exp_t e;
        logic [W-1:0] a;
        a = 20'hEC880;
        e = model(a, 20'd4, OP_ROL, 4'd0);  check("pin_rol4",  32'({e.data, e.carry}), 32'({20'hC880E, 1'b0}));
        e = model(a, 20'd4, OP_ROR, 4'd0);  check("pin_ror4",  32'({e.data, e.carry}), 32'({20'h0EC88, 1'b0}));
        e = model(a, 20'd4, OP_SHL, 4'd0);  check("pin_shl4",  32'({e.data, e.carry}), 32'({20'hC8800, 1'b0}));
        e = model(a, 20'd4, OP_SHR, 4'd0);  check("pin_shr4",  32'({e.data, e.carry}), 32'({20'h0EC88, 1'b0}));
        e = model(a, 20'd4, OP_SAR, 4'd0);  check("pin_sar4",  32'({e.data, e.carry}), 32'({20'hFEC88, 1'b0}));
        e = model(a, 20'd25, OP_ROL, 4'd0); check("pin_rol25", 32'({e.data, e.carry, e.neg}), 32'({20'h9101D, 2'b11}));
        e = model(a, 20'd20, OP_ROR, 4'd0); check("pin_ror20", 32'({e.data, e.carry}), 32'({20'hEC880, 1'b0}));
        e = model(a, 20'd20, OP_SHR, 4'd0); check("pin_shr20", 32'({e.data, e.zero, e.carry}), 32'({20'h00000, 2'b11}));
        e = model(a, 20'd30, OP_SAR, 4'd0); check("pin_sar30", 32'({e.data, e.carry}), 32'({20'hFFFFF, 1'b1}));
        e = model(a, 20'd0, OP_SHL, 4'd0);  check("pin_shl0",  32'({e.data, e.carry}), 32'({20'hEC880, 1'b0}));
        e = model(20'h12345, 20'd3, 3'd6, 4'd9);
        check("pin_illegal", 32'({e.data, e.ill, e.tag}), 32'({20'h12345, 1'b1, 4'd9}));
    endtask

    function automatic logic [W-1:0] rand_amount();
        case ($urandom_range(0, 4))
            0:       return W'($urandom_range(0, W + 5));
            1:       return W'(W);
            2:       return '0;
            3:       return W'($urandom);
            default: return W'(W - 1);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    bit rand_on;
    bit acc;

    initial begin
        pin_model();

        idle(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Back-to-back op sweep with no backpressure.
        out_ready = 1'b1;
        send(20'hEC880, 20'd4, OP_ROL, 4'd1);
        send(20'hEC880, 20'd4, OP_ROR, 4'd2);
        send(20'hEC880, 20'd4, OP_SHL, 4'd3);
        send(20'hEC880, 20'd4, OP_SHR, 4'd4);
        send(20'hEC880, 20'd4, OP_SAR, 4'd5);
        idle(4);

        send(20'hEC880, 20'd25, OP_ROL, 4'd6);
        send(20'hEC880, 20'd20, OP_ROR, 4'd7);
        send(20'hEC880, 20'd20, OP_SHR, 4'd8);
        send(20'hEC880, 20'd30, OP_SAR, 4'd10);
        send(20'hEC880, 20'd0,  OP_SHL, 4'd11);
        send(20'hEC880, 20'd21, OP_SHL, 4'd12);
        send(20'h12345, 20'd3,  3'd6,   4'd9);
        idle(4);

        // Backpressure: only two requests fit, outputs hold while stalled.
        out_ready = 1'b0;
        send(20'h0F0F1, 20'd3, OP_ROR, 4'd1);
        send(20'h80001, 20'd5, OP_SAR, 4'd2);
        fork
            send(20'h55555, 20'd1, OP_SHL, 4'd3);
            begin
                @(negedge clk);
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_tag_held", 32'(out_tag), 32'd1);
                idle(3);
                check("bp_tag_still_held", 32'(out_tag), 32'd1);
                out_ready = 1'b1;
            end
        join
        idle(5);

        // Flush with two in flight; the request offered during flush is refused.
        out_ready = 1'b0;
        send(20'hABCDE, 20'd7, OP_ROL, 4'd4);
        send(20'h13579, 20'd2, OP_SHR, 4'd5);
        flush = 1'b1;
        try_once(20'h2468A, 20'd1, OP_SHL, 4'd7, acc);
        flush = 1'b0;
        check("flush_refused", 32'(acc), 32'd0);
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        idle(5);

        // Randomized traffic with random backpressure and rare flushes.
        rand_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send(W'($urandom), rand_amount(), 3'($urandom_range(0, 7)), TW'($urandom));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    flush     = ($urandom_range(0, 49) == 0);
                end
                out_ready = 1'b1;
                flush     = 1'b0;
            end
        join
        idle(6);

        // Asynchronous reset in the middle of traffic.
        out_ready = 1'b0;
        send(20'hFFFFF, 20'd2, OP_ROL, 4'd13);
        send(20'h00F00, 20'd9, OP_SAR, 4'd14);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        idle(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(20'h80000, 20'd19, OP_SAR, 4'd15);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
